// File: rtl/rv_axi4_lite_read_slave.sv
// rtl/rv_axi4_lite_read_slave.sv - AXI4-Lite read slave bridging AR/R onto a single-beat memory read port
module rv_axi4_lite_read_slave #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int MEM_ADDR_WIDTH = 12,
  parameter int DATA_WIDTH     = 32,
  parameter int DECODE_ERR     = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  // AXI read address channel
  input  logic                      axi_ar_valid,
  output logic                      axi_ar_ready,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_ar_addr,
  input  logic [2:0]                axi_ar_prot,
  // AXI read data channel
  output logic                      axi_r_valid,
  input  logic                      axi_r_ready,
  output logic [DATA_WIDTH-1:0]     axi_r_data,
  output logic [1:0]                axi_r_resp,
  // memory request channel
  output logic                      mem_r_valid,
  input  logic                      mem_r_ready,
  output logic                      mem_r_op,
  output logic [MEM_ADDR_WIDTH-1:0] mem_r_addr,
  output logic [DATA_WIDTH-1:0]     mem_r_data,
  // memory response channel
  input  logic                      mem_rd_valid,
  output logic                      mem_rd_ready,
  input  logic [DATA_WIDTH-1:0]     mem_rd_data
);

  // Memory op encoding shared with the write slave; this block only reads.
  localparam logic RV_MEM_READ  = 1'b0;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Elaboration-time parameter sanity
  if (MEM_ADDR_WIDTH > AXI_ADDR_WIDTH) begin : g_chk_addr_width
    $error("MEM_ADDR_WIDTH must not exceed AXI_ADDR_WIDTH");
  end
  if (DATA_WIDTH != $bits(mem_rd_data)) begin : g_chk_data_width
    $error("AXI data width and memory data width must match");
  end

  typedef enum logic [1:0] {
    ST_ADDR = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t cs;
  state_t ns;

  logic [MEM_ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]     data_q;
  logic [1:0]                resp_q;

  // Protection attributes carry no meaning for this peripheral.
  logic unused_prot;
  assign unused_prot = ^axi_ar_prot;

  // Address bits above the memory window; only meaningful when the window is narrower than AXI.
  logic upper_nz;
  if (MEM_ADDR_WIDTH < AXI_ADDR_WIDTH) begin : g_upper
    assign upper_nz = |axi_ar_addr[AXI_ADDR_WIDTH-1:MEM_ADDR_WIDTH];
  end else begin : g_no_upper
    assign upper_nz = 1'b0;
  end

  logic decode_fail;
  assign decode_fail = (DECODE_ERR != 0) && upper_nz;

  logic ar_fire;
  logic rd_fire;
  assign ar_fire = (cs == ST_ADDR) && axi_ar_valid;
  assign rd_fire = (cs == ST_WAIT) && mem_rd_valid;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      cs <= ST_ADDR;
    end else begin
      cs <= ns;
    end
  end

  // Next-state decode; a decode error skips the memory entirely
  always_comb begin
    ns = cs;
    case (cs)
      ST_ADDR: begin
        if (axi_ar_valid) begin
          ns = decode_fail ? ST_RESP : ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_r_ready) begin
          ns = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_rd_valid) begin
          ns = ST_RESP;
        end
      end
      ST_RESP: begin
        if (axi_r_ready) begin
          ns = ST_ADDR;
        end
      end
      default: ns = ST_ADDR;
    endcase
  end

  // Handshake outputs decode from the current state only, so none depends on an AXI input
  always_comb begin
    axi_ar_ready = 1'b0;
    mem_r_valid  = 1'b0;
    mem_rd_ready = 1'b0;
    axi_r_valid  = 1'b0;
    case (cs)
      ST_ADDR: axi_ar_ready = 1'b1;
      ST_REQ:  mem_r_valid  = 1'b1;
      ST_WAIT: mem_rd_ready = 1'b1;
      ST_RESP: axi_r_valid  = 1'b1;
      default: axi_ar_ready = 1'b0;
    endcase
  end

  // Address capture on AR accept; read data/response load only when entering RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      data_q <= '0;
      resp_q <= RESP_OKAY;
    end else begin
      if (ar_fire) begin
        addr_q <= axi_ar_addr[MEM_ADDR_WIDTH-1:0];
        if (decode_fail) begin
          data_q <= '0;
          resp_q <= RESP_SLVERR;
        end
      end
      if (rd_fire) begin
        data_q <= mem_rd_data;
        resp_q <= RESP_OKAY;
      end
    end
  end

  assign mem_r_op   = RV_MEM_READ;
  assign mem_r_addr = addr_q;
  assign mem_r_data = '0;
  assign axi_r_data = data_q;
  assign axi_r_resp = resp_q;

endmodule

// File: tb/tb_rv_axi4_lite_read_slave.sv
// tb/tb_rv_axi4_lite_read_slave.sv - scoreboard bench for rv_axi4_lite_read_slave
`timescale 1ns/1ps
module tb_rv_axi4_lite_read_slave;
  localparam int AW = 32;
  localparam int MW = 12;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          axi_ar_valid;
  logic          axi_ar_ready;
  logic [AW-1:0] axi_ar_addr;
  logic [2:0]    axi_ar_prot;
  logic          axi_r_valid;
  logic          axi_r_ready;
  logic [DW-1:0] axi_r_data;
  logic [1:0]    axi_r_resp;
  logic          mem_r_valid;
  logic          mem_r_ready;
  logic          mem_r_op;
  logic [MW-1:0] mem_r_addr;
  logic [DW-1:0] mem_r_data;
  logic          mem_rd_valid;
  logic          mem_rd_ready;
  logic [DW-1:0] mem_rd_data;

  rv_axi4_lite_read_slave #(
    .AXI_ADDR_WIDTH(AW), .MEM_ADDR_WIDTH(MW), .DATA_WIDTH(DW), .DECODE_ERR(1)
  ) dut (
    .clk(clk), .rst(rst),
    .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready),
    .axi_ar_addr(axi_ar_addr), .axi_ar_prot(axi_ar_prot),
    .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready),
    .axi_r_data(axi_r_data), .axi_r_resp(axi_r_resp),
    .mem_r_valid(mem_r_valid), .mem_r_ready(mem_r_ready), .mem_r_op(mem_r_op),
    .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data),
    .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready), .mem_rd_data(mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    resp;
  } rexp_t;

  rexp_t         rq[$];
  logic [MW-1:0] aq[$];

  int req_stall_cfg = 0;
  int rsp_delay_cfg = 0;
  int r_stall_cfg   = 0;

  int ar_hs_cyc       = 0;
  int rvalid_rise_cyc = 0;
  int r_fire_cyc      = 0;
  int r_beats         = 0;
  int req_count       = 0;

  function automatic logic [DW-1:0] mem_word(input logic [MW-1:0] a);
    return (a == 12'h010) ? 32'hDEAD_BEEF : {20'hC0DE0, a};
  endfunction

  // Memory model: acts 1ns after each falling edge, reacting to the handshakes of the previous rising edge
  initial begin : mem_model
    bit            req_fire, rsp_fire, pending, prev_mvalid, hold_valid;
    int            stall_left, wait_left;
    logic [MW-1:0] paddr, hold_addr;
    req_fire = 0; rsp_fire = 0; pending = 0; prev_mvalid = 0; hold_valid = 0;
    stall_left = 0; wait_left = 0; paddr = '0; hold_addr = '0;
    mem_r_ready = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        req_fire = 0; rsp_fire = 0; pending = 0; prev_mvalid = 0; hold_valid = 0;
        mem_r_ready = 1'b0; mem_rd_valid = 1'b0;
        aq.delete();
      end else begin
        if (rsp_fire) mem_rd_valid = 1'b0;
        if (req_fire) begin
          pending   = 1;
          wait_left = rsp_delay_cfg;
        end
        if (hold_valid) begin
          chk("mem_r_valid held", mem_r_valid, 1);
          if (mem_r_valid) chk("mem_r_addr stable", mem_r_addr, hold_addr);
        end
        if (mem_r_valid && !prev_mvalid) stall_left = req_stall_cfg;
        if (mem_r_valid && stall_left > 0) begin
          mem_r_ready = 1'b0;
          stall_left--;
        end else begin
          mem_r_ready = mem_r_valid;
        end
        req_fire = mem_r_valid && mem_r_ready;
        if (req_fire) begin
          req_count++;
          paddr = mem_r_addr;
          if (aq.size() == 0) chk("unexpected mem request", 1, 0);
          else chk("mem_r_addr", mem_r_addr, aq.pop_front());
          chk("mem_r_op", mem_r_op, 0);
          chk("mem_r_data", mem_r_data, 0);
        end
        hold_valid  = mem_r_valid && !mem_r_ready;
        hold_addr   = mem_r_addr;
        prev_mvalid = mem_r_valid;
        if (pending && !mem_rd_valid) begin
          if (wait_left == 0) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = mem_word(paddr);
            pending      = 0;
          end else begin
            wait_left--;
          end
        end
        rsp_fire = mem_rd_valid && mem_rd_ready;
      end
    end
  end

  // R monitor: drives RREADY, checks stability, pops the scoreboard on each R handshake
  initial begin : r_monitor
    bit            prev_rvalid, held;
    int            stall_left;
    logic [DW-1:0] hdata;
    logic [1:0]    hresp;
    rexp_t         e;
    prev_rvalid = 0; held = 0; stall_left = 0; hdata = '0; hresp = '0;
    axi_r_ready = 1'b1;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        rq.delete();
        held = 0; prev_rvalid = 0;
        axi_r_ready = 1'b1;
      end else begin
        if (held) begin
          chk("r_valid held", axi_r_valid, 1);
          if (axi_r_valid) begin
            chk("r_data stable", axi_r_data, hdata);
            chk("r_resp stable", axi_r_resp, hresp);
          end
        end
        if (axi_r_valid && !prev_rvalid) begin
          rvalid_rise_cyc = cyc;
          stall_left = r_stall_cfg;
        end
        if (axi_r_valid && stall_left > 0) begin
          axi_r_ready = 1'b0;
          stall_left--;
        end else begin
          axi_r_ready = 1'b1;
        end
        if (axi_r_valid || mem_r_valid || mem_rd_ready) chk("ar_ready low while busy", axi_ar_ready, 0);
        if (axi_r_valid && axi_r_ready) begin
          r_fire_cyc = cyc;
          r_beats++;
          if (rq.size() == 0) begin
            chk("unexpected R beat", 1, 0);
          end else begin
            e = rq.pop_front();
            chk("r_data", axi_r_data, e.data);
            chk("r_resp", axi_r_resp, e.resp);
          end
          held = 0;
        end else begin
          held  = axi_r_valid;
          hdata = axi_r_data;
          hresp = axi_r_resp;
        end
        prev_rvalid = axi_r_valid;
      end
    end
  end

  // Issue one AR; returns on the falling edge after the handshake edge
  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] resp,
                         input bit to_mem);
    int n;
    n = 0;
    axi_ar_valid = 1'b1;
    axi_ar_addr  = a;
    while (!axi_ar_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!axi_ar_ready) begin
      chk("ar handshake timeout", 0, 1);
      axi_ar_valid = 1'b0;
    end else begin
      ar_hs_cyc = cyc;
      rq.push_back(rexp_t'{data: d, resp: resp});
      if (to_mem) aq.push_back(a[MW-1:0]);
      @(negedge clk);
    end
  endtask

  task automatic wait_beats(input int target);
    int n;
    n = 0;
    while (r_beats < target && n < 100) begin
      @(negedge clk); #2;
      n++;
    end
    if (r_beats < target) chk("R beat timeout", r_beats, target);
  endtask

  initial begin : stimulus
    int b, h0, h1, h2, rc, n;
    rst = 1'b1; axi_ar_valid = 1'b0; axi_ar_addr = '0; axi_ar_prot = 3'b000;
    repeat (3) @(negedge clk);
    chk("reset ar_ready", axi_ar_ready, 1);
    chk("reset r_valid", axi_r_valid, 0);
    chk("reset mem_r_valid", mem_r_valid, 0);
    chk("reset mem_rd_ready", mem_rd_ready, 0);
    chk("reset r_data", axi_r_data, 0);
    chk("reset r_resp", axi_r_resp, 0);
    chk("reset mem_r_addr", mem_r_addr, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset ar_ready", axi_ar_ready, 1);

    // Single read
    b = r_beats;
    do_read(32'h0000_0010, 32'hDEAD_BEEF, 2'b00, 1);
    axi_ar_valid = 1'b0;
    wait_beats(b + 1);
    chk("single read latency", rvalid_rise_cyc - ar_hs_cyc, 3);

    // Backpressure on every channel: 3 + 5 + 4 cycles to RVALID
    req_stall_cfg = 5; rsp_delay_cfg = 4; r_stall_cfg = 3;
    b = r_beats;
    do_read(32'h0000_0024, 32'hC0DE_0024, 2'b00, 1);
    axi_ar_valid = 1'b0;
    wait_beats(b + 1);
    chk("backpressure latency", rvalid_rise_cyc - ar_hs_cyc, 12);
    chk("backpressure R hold", r_fire_cyc - rvalid_rise_cyc, 3);
    req_stall_cfg = 0; rsp_delay_cfg = 0; r_stall_cfg = 0;
    do_read(32'h0000_0020, 32'hC0DE_0020, 2'b00, 1);
    axi_ar_valid = 1'b0;
    chk("AR accepted right after R", ar_hs_cyc - r_fire_cyc, 1);
    wait_beats(b + 2);

    // Decode error: SLVERR, no memory request
    b = r_beats;
    rc = req_count;
    do_read(32'h0001_0004, 32'h0000_0000, 2'b10, 0);
    axi_ar_valid = 1'b0;
    wait_beats(b + 1);
    chk("decode error latency", rvalid_rise_cyc - ar_hs_cyc, 1);
    repeat (3) @(negedge clk);
    chk("decode error mem requests", req_count - rc, 0);

    // Back-to-back with ARVALID held high
    b = r_beats;
    do_read(32'h0000_0004, 32'hC0DE_0004, 2'b00, 1); h0 = ar_hs_cyc;
    do_read(32'h0000_0008, 32'hC0DE_0008, 2'b00, 1); h1 = ar_hs_cyc;
    do_read(32'h0000_000C, 32'hC0DE_000C, 2'b00, 1); h2 = ar_hs_cyc;
    axi_ar_valid = 1'b0;
    wait_beats(b + 3);
    chk("b2b AR spacing 1", h1 - h0, 4);
    chk("b2b AR spacing 2", h2 - h1, 4);

    // Reset while waiting on the memory response
    rsp_delay_cfg = 10;
    b = r_beats;
    do_read(32'h0000_0030, 32'hC0DE_0030, 2'b00, 1);
    axi_ar_valid = 1'b0;
    n = 0;
    while (!mem_rd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reached WAIT", mem_rd_ready, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid-op reset ar_ready", axi_ar_ready, 1);
    chk("mid-op reset r_valid", axi_r_valid, 0);
    chk("mid-op reset mem_rd_ready", mem_rd_ready, 0);
    chk("mid-op reset r_data", axi_r_data, 0);
    rst = 1'b0;
    rsp_delay_cfg = 0;
    repeat (4) @(negedge clk);
    chk("no R after reset", r_beats - b, 0);
    do_read(32'h0000_000C, 32'hC0DE_000C, 2'b00, 1);
    axi_ar_valid = 1'b0;
    wait_beats(b + 1);
    chk("post-reset read latency", rvalid_rise_cyc - ar_hs_cyc, 3);

    repeat (3) @(negedge clk);
    chk("scoreboard drained", rq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
